// File: rtl/id_exe_pipe_reg_if.sv
// ID->EXE stage bundle: decoded fields in from ID, registered copies out to EXE,
// plus the debug stall/flush counters.
interface id_exe_pipe_reg_if #(
    parameter int LEN_ADDRESS       = 32,
    parameter int LEN_SHIFT_OPERAND = 12,
    parameter int CNT_W             = 16
);
    logic                         freeze;
    logic                         flush;

    logic                         valid_in;
    logic [LEN_ADDRESS-1:0]       pc_in;
    logic                         wb_en_in;
    logic                         mem_r_en_in;
    logic                         mem_w_en_in;
    logic [3:0]                   exe_cmd_in;
    logic                         b_in;
    logic                         s_in;
    logic                         imm_in;
    logic [LEN_ADDRESS-1:0]       val_rn_in;
    logic [LEN_ADDRESS-1:0]       val_rm_in;
    logic [LEN_SHIFT_OPERAND-1:0] shift_operand_in;
    logic [23:0]                  signed_imm24_in;
    logic [3:0]                   dest_in;
    logic [3:0]                   src1_in;
    logic [3:0]                   src2_in;
    logic [3:0]                   sr_in;

    logic                         valid_out;
    logic [LEN_ADDRESS-1:0]       pc_out;
    logic                         wb_en_out;
    logic                         mem_r_en_out;
    logic                         mem_w_en_out;
    logic [3:0]                   exe_cmd_out;
    logic                         b_out;
    logic                         s_out;
    logic                         imm_out;
    logic [LEN_ADDRESS-1:0]       val_rn_out;
    logic [LEN_ADDRESS-1:0]       val_rm_out;
    logic [LEN_SHIFT_OPERAND-1:0] shift_operand_out;
    logic [23:0]                  signed_imm24_out;
    logic [3:0]                   dest_out;
    logic [3:0]                   src1_out;
    logic [3:0]                   src2_out;
    logic [3:0]                   sr_out;

    logic [CNT_W-1:0]             stall_count;
    logic [CNT_W-1:0]             flush_count;

    modport master (
        output freeze, flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
               exe_cmd_in, b_in, s_in, imm_in, val_rn_in, val_rm_in, shift_operand_in,
               signed_imm24_in, dest_in, src1_in, src2_in, sr_in,
        input  valid_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out,
               b_out, s_out, imm_out, val_rn_out, val_rm_out, shift_operand_out,
               signed_imm24_out, dest_out, src1_out, src2_out, sr_out,
               stall_count, flush_count
    );

    modport slave (
        input  freeze, flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
               exe_cmd_in, b_in, s_in, imm_in, val_rn_in, val_rm_in, shift_operand_in,
               signed_imm24_in, dest_in, src1_in, src2_in, sr_in,
        output valid_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, exe_cmd_out,
               b_out, s_out, imm_out, val_rn_out, val_rm_out, shift_operand_out,
               signed_imm24_out, dest_out, src1_out, src2_out, sr_out,
               stall_count, flush_count
    );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register, 1-cycle latency, no in->out combinational path.
// freeze holds every output (stall), flush loads a bubble; flush beats freeze.
module id_exe_pipe_reg #(
    parameter int LEN_ADDRESS       = 32,
    parameter int LEN_SHIFT_OPERAND = 12,
    parameter int CNT_W             = 16
) (
    input  logic clk,
    input  logic rst,
    id_exe_pipe_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.valid_out         <= 1'b0;
            bus.pc_out            <= '0;
            bus.wb_en_out         <= 1'b0;
            bus.mem_r_en_out      <= 1'b0;
            bus.mem_w_en_out      <= 1'b0;
            bus.exe_cmd_out       <= '0;
            bus.b_out             <= 1'b0;
            bus.s_out             <= 1'b0;
            bus.imm_out           <= 1'b0;
            bus.val_rn_out        <= '0;
            bus.val_rm_out        <= '0;
            bus.shift_operand_out <= '0;
            bus.signed_imm24_out  <= '0;
            bus.dest_out          <= '0;
            bus.src1_out          <= '0;
            bus.src2_out          <= '0;
            bus.sr_out            <= '0;
        end else if (!bus.freeze) begin
            bus.valid_out         <= bus.valid_in;
            bus.pc_out            <= bus.pc_in;
            // An invalid slot still carries data but must never write state.
            bus.wb_en_out         <= bus.wb_en_in    & bus.valid_in;
            bus.mem_r_en_out      <= bus.mem_r_en_in & bus.valid_in;
            bus.mem_w_en_out      <= bus.mem_w_en_in & bus.valid_in;
            bus.b_out             <= bus.b_in        & bus.valid_in;
            bus.s_out             <= bus.s_in        & bus.valid_in;
            bus.exe_cmd_out       <= bus.exe_cmd_in;
            bus.imm_out           <= bus.imm_in;
            bus.val_rn_out        <= bus.val_rn_in;
            bus.val_rm_out        <= bus.val_rm_in;
            bus.shift_operand_out <= bus.shift_operand_in;
            bus.signed_imm24_out  <= bus.signed_imm24_in;
            bus.dest_out          <= bus.dest_in;
            bus.src1_out          <= bus.src1_in;
            bus.src2_out          <= bus.src2_in;
            bus.sr_out            <= bus.sr_in;
        end
    end

    // Debug counters saturate rather than wrap; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_count <= '0;
            bus.flush_count <= '0;
        end else if (bus.flush) begin
            if (bus.flush_count != CNT_MAX)
                bus.flush_count <= bus.flush_count + 1'b1;
        end else if (bus.freeze) begin
            if (bus.stall_count != CNT_MAX)
                bus.stall_count <= bus.stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Scoreboard bench: drivers push the expected post-edge state per cycle,
// a monitor pops and compares it just after each rising edge.
module tb_id_exe_pipe_reg;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    id_exe_pipe_reg_if #(.CNT_W(16)) if1 ();
    id_exe_pipe_reg_if #(.CNT_W(4))  if2 ();

    id_exe_pipe_reg #(.CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(if1.slave));
    id_exe_pipe_reg #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst2), .bus(if2.slave));

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        wb, mr, mw;
        logic [3:0]  cmd;
        logic        b, s, imm;
        logic [31:0] rn, rm;
        logic [11:0] sh;
        logic [23:0] imm24;
        logic [3:0]  dest, s1, s2, sr;
    } stage_t;

    typedef struct packed {
        stage_t      f;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t       q1[$];
    string      n1[$];
    logic [7:0] q2[$];
    string      n2[$];

    int checks   = 0;
    int failures = 0;

    stage_t      m_f;
    logic [15:0] m_sc, m_fc;
    logic [3:0]  m2_sc;

    function automatic stage_t dut_out();
        stage_t o;
        o = '{valid: if1.valid_out, pc: if1.pc_out, wb: if1.wb_en_out,
              mr: if1.mem_r_en_out, mw: if1.mem_w_en_out, cmd: if1.exe_cmd_out,
              b: if1.b_out, s: if1.s_out, imm: if1.imm_out, rn: if1.val_rn_out,
              rm: if1.val_rm_out, sh: if1.shift_operand_out,
              imm24: if1.signed_imm24_out, dest: if1.dest_out, s1: if1.src1_out,
              s2: if1.src2_out, sr: if1.sr_out};
        return o;
    endfunction

    function automatic stage_t rnd_stage();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return stage_t'(r[158:0]);
    endfunction

    task automatic drive_in(input stage_t v);
        if1.valid_in         = v.valid;
        if1.pc_in            = v.pc;
        if1.wb_en_in         = v.wb;
        if1.mem_r_en_in      = v.mr;
        if1.mem_w_en_in      = v.mw;
        if1.exe_cmd_in       = v.cmd;
        if1.b_in             = v.b;
        if1.s_in             = v.s;
        if1.imm_in           = v.imm;
        if1.val_rn_in        = v.rn;
        if1.val_rm_in        = v.rm;
        if1.shift_operand_in = v.sh;
        if1.signed_imm24_in  = v.imm24;
        if1.dest_in          = v.dest;
        if1.src1_in          = v.s1;
        if1.src2_in          = v.s2;
        if1.sr_in            = v.sr;
    endtask

    // Drive one cycle on the 16-bit-counter instance and queue what it must show.
    task automatic step(input string name, input logic r, input logic fl,
                        input logic fz, input stage_t v);
        @(negedge clk);
        rst        = r;
        if1.flush  = fl;
        if1.freeze = fz;
        drive_in(v);
        if (r) begin
            m_f = '0; m_sc = '0; m_fc = '0;
        end else if (fl) begin
            m_f = '0;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end else if (fz) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        end else begin
            m_f = v;
            if (!v.valid) begin
                m_f.wb = 1'b0; m_f.mr = 1'b0; m_f.mw = 1'b0; m_f.b = 1'b0; m_f.s = 1'b0;
            end
        end
        q1.push_back({m_f, m_sc, m_fc});
        n1.push_back(name);
    endtask

    task automatic step2(input string name, input logic r, input logic fz);
        @(negedge clk);
        rst2       = r;
        if2.freeze = fz;
        if (r) m2_sc = '0;
        else if (fz && m2_sc != 4'hF) m2_sc = m2_sc + 4'd1;
        q2.push_back({m2_sc, 4'h0});
        n2.push_back(name);
    endtask

    initial begin : monitor
        exp_t       e, g;
        logic [7:0] e2, g2;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e  = q1.pop_front();
                nm = n1.pop_front();
                g  = {dut_out(), if1.stall_count, if1.flush_count};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", nm, g, e);
                end
            end
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                nm = n2.pop_front();
                g2 = {if2.stall_count, if2.flush_count};
                checks++;
                if (g2 !== e2) begin
                    failures++;
                    $display("FAIL %s: got stall/flush %h expected %h", nm, g2, e2);
                end
            end
        end
    end

    initial begin : stimulus
        stage_t v, v3, v5;
        rst = 1'b1; rst2 = 1'b1;
        if1.flush = 1'b0; if1.freeze = 1'b0; drive_in('0);
        if2.flush = 1'b0; if2.freeze = 1'b0;
        if2.valid_in = 1'b0; if2.pc_in = '0; if2.wb_en_in = 1'b0;
        if2.mem_r_en_in = 1'b0; if2.mem_w_en_in = 1'b0; if2.exe_cmd_in = '0;
        if2.b_in = 1'b0; if2.s_in = 1'b0; if2.imm_in = 1'b0; if2.val_rn_in = '0;
        if2.val_rm_in = '0; if2.shift_operand_in = '0; if2.signed_imm24_in = '0;
        if2.dest_in = '0; if2.src1_in = '0; if2.src2_in = '0; if2.sr_in = '0;
        m_f = '0; m_sc = '0; m_fc = '0; m2_sc = '0;

        // Reset dominates random inputs, including random flush/freeze.
        for (int i = 0; i < 2; i++)
            step("reset", 1'b1, 1'($urandom), 1'($urandom), rnd_stage());

        v = '0;
        v.valid = 1'b1; v.pc = 32'h10; v.rm = 32'h8000_0001; v.sh = 12'h0C3;
        v.wb = 1'b1; v.cmd = 4'h4; v.dest = 4'h3; v.sr = 4'b1010; v.imm24 = 24'h80_0001;
        step("load", 1'b0, 1'b0, 1'b0, v);

        for (int i = 0; i < 3; i++)
            step("freeze_hold", 1'b0, 1'b0, 1'b1, rnd_stage());
        v3 = rnd_stage();
        v3.valid = 1'b1;
        step("release", 1'b0, 1'b0, 1'b0, v3);

        v3.wb = 1'b1;
        step("flush_over_freeze", 1'b0, 1'b1, 1'b1, v3);
        step("freeze_on_bubble", 1'b0, 1'b0, 1'b1, v3);

        v5 = '0;
        v5.valid = 1'b0; v5.mw = 1'b1; v5.mr = 1'b1; v5.wb = 1'b1; v5.b = 1'b1; v5.s = 1'b1;
        v5.pc = 32'hABCD_0004; v5.rn = 32'h1234_5678; v5.sh = 12'hFFF;
        v5.dest = 4'hE; v5.s1 = 4'h1; v5.s2 = 4'h2; v5.sr = 4'b0110;
        step("invalid_slot", 1'b0, 1'b0, 1'b0, v5);

        step("reset_mid_stall", 1'b1, 1'b1, 1'b1, rnd_stage());
        step("post_reset_freeze", 1'b0, 1'b0, 1'b1, v);
        step("post_reset_flush", 1'b0, 1'b1, 1'b0, v);
        step("post_reset_load", 1'b0, 1'b0, 1'b0, v);

        // Narrow counter instance: saturation at 4'hF, then clear by reset.
        step2("cnt4_reset", 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            step2("cnt4_saturate", 1'b0, 1'b1);
        step2("cnt4_clear", 1'b1, 1'b1);
        step2("cnt4_restart", 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q1.size(), q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
